button_event_gen: RTL and testbench
===================================

Name: button_event_gen

Overview:
- Front end that turns the raw panel push-buttons (SET, INC, SW) into the one-cycle event pulses set, inc, linc and sw that the clock/alarm/stopwatch mode FSM consumes.
- Per button: synchronises, debounces and edge-detects. INC also gets short-press vs long-press classification.
- Guarantees at most one event pulse per cycle, so the FSM's mutually-exclusive decode always sees a clean pattern.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to change a debounced level (>=2).
- LONG_CYCLES, 1000, debounced INC hold cycles that classify a long press (> DEBOUNCE_CYCLES).
- ACTIVE_LOW, 0, 1 = raw buttons read 0 when pressed; inverted after the synchroniser.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous, active-high reset.
- btn_set_raw, input, 1, raw SET button, asynchronous.
- btn_inc_raw, input, 1, raw INC button, asynchronous.
- btn_sw_raw, input, 1, raw SW button, asynchronous.
- set, output, 1, one-cycle pulse: SET pressed.
- inc, output, 1, one-cycle pulse: INC short press, released before LONG_CYCLES.
- linc, output, 1, one-cycle pulse: INC held LONG_CYCLES.
- sw, output, 1, one-cycle pulse: SW pressed.
- inc_held, output, 1, debounced INC level, for display blink or status.

Behaviour:
- Reset: set, inc, linc, sw and inc_held = 0. Synchronisers, debounced levels and counters = 0. Pending flags cleared. INC FSM = IDLE. All arm flags = 0.
- Synchroniser: 2-flop per button, then ACTIVE_LOW inversion.
- Debounce:
  - Per-button counter, width $clog2(DEBOUNCE_CYCLES+1).
  - Counter resets to 0 whenever the synchronised sample equals the debounced level.
  - Otherwise it increments. On reaching DEBOUNCE_CYCLES-1 with the sample still differing, the debounced level toggles next edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the level.
- Arm (post-reset lockout):
  - Each button starts disarmed after reset.
  - A button becomes armed once its debounced level has been 0 for one cycle.
  - Edges are ignored while disarmed, so a button held through reset generates no event.
- SET / SW: debounced rising edge while armed sets that button's pending flag.
- INC FSM, hold counter width $clog2(LONG_CYCLES+1):
  - IDLE: on debounced rise while armed, clear counter and go to PRESSED.
  - PRESSED: counter increments each cycle.
    - Debounced fall before counter == LONG_CYCLES-1: set pend_inc, go to IDLE.
    - Counter reaches LONG_CYCLES-1 while held: set pend_linc, go to LONG.
  - LONG: counter holds (saturates). Debounced fall goes to IDLE with no inc. No repeated linc.
- Output arbiter:
  - Each cycle emits the highest-priority pending flag as a registered pulse and clears only that flag.
  - Priority: sw > set > linc > inc.
  - Others stay pending and are emitted in later cycles, in priority order; none are lost.
  - A new edge on a button whose flag is still pending is merged (flag stays 1).
- Latency with no contention:
  - Raw edge sampled at edge N -> sync valid N+2 -> debounced level N+2+DEBOUNCE_CYCLES -> pulse high at N+3+DEBOUNCE_CYCLES, for exactly one cycle.
  - linc goes high LONG_CYCLES+1 cycles after the debounced rise.
  - inc goes high 2 cycles after the debounced fall.
- Mutual exclusion: set+inc+linc+sw <= 1 in every cycle (assertion).
- Reset mid-operation: everything returns to reset values next edge. Pending events are discarded, the INC FSM returns to IDLE and all arm flags are cleared.

Decomposition:
- Shared package clk_ui_pkg: INC FSM enum (IDLE, PRESSED, LONG), event priority encoding, and the default DEBOUNCE_CYCLES/LONG_CYCLES constants shared with the mode FSM bench.
- Sub-module key_debounce (2-flop sync + inversion + debounce counter + debounced level + rise/fall strobes), instantiated three times.
- INC classifier and arbiter stay in the top.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=0):
- SET clean press at edge 10, held 30 cycles -> set high only at cycle 17; no other pulse; nothing on release.
- INC pressed 3 cycles then released (glitch) -> inc_held stays 0; no events. INC pressed 10 cycles -> single inc pulse 2 cycles after debounced fall; linc never asserted.
- INC held 50 cycles -> inc_held rises at +6; linc pulse once at +6+21; no inc on release.
- SET and SW raw rise on same edge -> sw pulse at cycle N+7, set pulse at N+8; never both in one cycle.
- SW held from before reset deassert, released, pressed again -> no event for the held press; one sw pulse for the new press.
- rst asserted while INC FSM in PRESSED (counter=12) -> all outputs 0 next edge; INC released after reset -> no inc pulse.

Source files
------------

// File: rtl/clk_ui_pkg.sv
// Shared definitions for the clock/alarm/stopwatch panel front end:
// INC classifier states, the event vector with its priority order, and
// default debounce / long-press timing constants.
package clk_ui_pkg;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
    localparam int unsigned DEF_LONG_CYCLES     = 1000;

    // INC press classifier states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } inc_state_t;

    // Event vector; field order is the priority order, MSB highest
    typedef struct packed {
        logic sw;
        logic set;
        logic linc;
        logic inc;
    } ev_vec_t;

    // One-hot of the highest-priority pending event (all zero if none)
    function automatic ev_vec_t ev_grant(input ev_vec_t pend);
        ev_vec_t g;
        g = '0;
        if (pend.sw)        g.sw   = 1'b1;
        else if (pend.set)  g.set  = 1'b1;
        else if (pend.linc) g.linc = 1'b1;
        else if (pend.inc)  g.inc  = 1'b1;
        return g;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-button conditioning: 2-flop synchroniser, registered polarity
// correction, and a stability counter that changes the debounced level only
// after DEBOUNCE_CYCLES consecutive differing samples.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   i_raw      - raw asynchronous button input
//   o_sample   - synchronised, polarity-corrected sample (1 = pressed)
//   o_level    - debounced level (1 = pressed)
//   o_edge_c   - combinational strobe: o_level toggles on the next edge
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_sample,
    output logic o_level,
    output logic o_edge_c
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_sample;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          w_differ;
    logic          w_expire;

    assign w_differ = (r_sample != r_level);
    // Last of DEBOUNCE_CYCLES consecutive differing samples
    assign w_expire = w_differ && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

    // Synchroniser, polarity correction and stability counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_sample <= 1'b0;
            r_level  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1     <= i_raw;
            r_s2     <= r_s1;
            r_sample <= r_s2 ^ ACTIVE_LOW;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_expire) begin
                r_cnt   <= '0;
                r_level <= ~r_level;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_sample = r_sample;
    assign o_level  = r_level;
    assign o_edge_c = w_expire;

endmodule

// File: rtl/button_event_gen.sv
// Turns the raw SET / INC / SW panel buttons into one-cycle event pulses for
// the mode FSM. INC is classified into short (inc) and long (linc) presses.
// A priority arbiter guarantees at most one pulse per cycle.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   i_btn_*_raw     - raw asynchronous buttons
//   o_set, o_sw     - pulse on debounced press
//   o_inc           - pulse on INC released before LONG_CYCLES
//   o_linc          - pulse once when INC held LONG_CYCLES
//   o_inc_held      - debounced INC level
module button_event_gen
    import clk_ui_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_set_raw,
    input  logic i_btn_inc_raw,
    input  logic i_btn_sw_raw,
    output logic o_set,
    output logic o_inc,
    output logic o_linc,
    output logic o_sw,
    output logic o_inc_held
);

    localparam int unsigned HW = $clog2(LONG_CYCLES + 1);

    logic w_set_sample, w_set_level, w_set_edge;
    logic w_inc_sample, w_inc_level, w_inc_edge;
    logic w_sw_sample,  w_sw_level,  w_sw_edge;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(ACTIVE_LOW)) u_key_set (
        .clk(clk), .rst(rst), .i_raw(i_btn_set_raw),
        .o_sample(w_set_sample), .o_level(w_set_level), .o_edge_c(w_set_edge)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(ACTIVE_LOW)) u_key_inc (
        .clk(clk), .rst(rst), .i_raw(i_btn_inc_raw),
        .o_sample(w_inc_sample), .o_level(w_inc_level), .o_edge_c(w_inc_edge)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(ACTIVE_LOW)) u_key_sw (
        .clk(clk), .rst(rst), .i_raw(i_btn_sw_raw),
        .o_sample(w_sw_sample), .o_level(w_sw_level), .o_edge_c(w_sw_edge)
    );

    logic [1:0]  r_prime_cnt;
    logic        w_primed;
    logic        r_arm_set, r_arm_inc, r_arm_sw;
    logic        r_inc_rise, r_inc_fall;
    inc_state_t  r_state, w_state_next;
    logic [HW-1:0] r_hold_cnt, w_hold_next, w_hold_inc;
    logic        w_new_inc, w_new_linc;
    ev_vec_t     r_pend, w_new, w_grant;

    // Sample pipeline is three flops deep; until it has refilled after reset
    // a sample of 0 says nothing about the real button.
    assign w_primed = (r_prime_cnt == 2'd3);

    assign w_new.sw   = w_sw_edge  & ~w_sw_level  & r_arm_sw;
    assign w_new.set  = w_set_edge & ~w_set_level & r_arm_set;
    assign w_new.linc = w_new_linc;
    assign w_new.inc  = w_new_inc;

    assign w_grant = ev_grant(r_pend);

    // INC classifier next state
    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold_cnt;
        w_new_inc    = 1'b0;
        w_new_linc   = 1'b0;
        w_hold_inc   = r_hold_cnt + HW'(1);
        unique case (r_state)
            IDLE: begin
                if (r_inc_rise) begin
                    w_hold_next  = '0;
                    w_state_next = PRESSED;
                end
            end
            PRESSED: begin
                w_hold_next = w_hold_inc;
                // A release on the same cycle as the threshold still counts as short
                if (r_inc_fall) begin
                    w_new_inc    = 1'b1;
                    w_state_next = IDLE;
                end else if (w_hold_inc == HW'(LONG_CYCLES - 1)) begin
                    w_new_linc   = 1'b1;
                    w_state_next = LONG;
                end
            end
            LONG: begin
                if (r_inc_fall) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Arming, INC strobes, classifier state, pending flags and output pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prime_cnt <= 2'd0;
            r_arm_set   <= 1'b0;
            r_arm_inc   <= 1'b0;
            r_arm_sw    <= 1'b0;
            r_inc_rise  <= 1'b0;
            r_inc_fall  <= 1'b0;
            r_state     <= IDLE;
            r_hold_cnt  <= '0;
            r_pend      <= '0;
            o_set       <= 1'b0;
            o_inc       <= 1'b0;
            o_linc      <= 1'b0;
            o_sw        <= 1'b0;
        end else begin
            if (!w_primed) begin
                r_prime_cnt <= r_prime_cnt + 2'd1;
            end
            // Armed once the button is seen genuinely released
            r_arm_set <= r_arm_set | (w_primed & ~w_set_sample & ~w_set_level);
            r_arm_inc <= r_arm_inc | (w_primed & ~w_inc_sample & ~w_inc_level);
            r_arm_sw  <= r_arm_sw  | (w_primed & ~w_sw_sample  & ~w_sw_level);
            r_inc_rise <= w_inc_edge & ~w_inc_level & r_arm_inc;
            r_inc_fall <= w_inc_edge &  w_inc_level;
            r_state    <= w_state_next;
            r_hold_cnt <= w_hold_next;
            r_pend     <= ev_vec_t'((r_pend & ~w_grant) | w_new);
            o_sw       <= w_grant.sw;
            o_set      <= w_grant.set;
            o_linc     <= w_grant.linc;
            o_inc      <= w_grant.inc;
        end
    end

    assign o_inc_held = w_inc_level;

    a_one_event: assert property (@(posedge clk) disable iff (rst)
        $onehot0({o_sw, o_set, o_linc, o_inc}));

endmodule

// File: tb/tb_button_event_gen.sv
module tb_button_event_gen;

    localparam logic [3:0] EV_SW   = 4'b1000;
    localparam logic [3:0] EV_SET  = 4'b0100;
    localparam logic [3:0] EV_LINC = 4'b0010;
    localparam logic [3:0] EV_INC  = 4'b0001;
    localparam logic [3:0] EV_NONE = 4'b0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_set = 1'b0;
    logic btn_inc = 1'b0;
    logic btn_sw  = 1'b0;
    logic o_set, o_inc, o_linc, o_sw, o_inc_held;

    button_event_gen #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES(20),
        .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_btn_set_raw(btn_set),
        .i_btn_inc_raw(btn_inc),
        .i_btn_sw_raw(btn_sw),
        .o_set(o_set),
        .o_inc(o_inc),
        .o_linc(o_linc),
        .o_sw(o_sw),
        .o_inc_held(o_inc_held)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] ev;
    } exp_t;

    typedef struct {
        int         btn;   // 0 SET, 1 INC, 2 SW
        int         hold;  // raw cycles held
        logic [3:0] ev;    // expected event, 0 = none
        int         lat;   // pulse cycle relative to first sampled edge
    } vec_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Scoreboard: every pulse must match the head of the expected queue
    always begin
        logic [3:0] ev;
        exp_t       e;
        @(posedge clk);
        #1;
        ev = {o_sw, o_set, o_linc, o_inc};
        if (ev != EV_NONE) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse cyc=%0d got=%b required=none", cyc, ev);
            end else begin
                e = exp_q.pop_front();
                if (e.ev != ev || e.cyc != cyc) begin
                    n_bad++;
                    $display("FAIL pulse cyc=%0d got=%b required cyc=%0d ev=%b", cyc, ev, e.cyc, e.ev);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_pulse cyc=%0d required cyc=%0d ev=%b", cyc, exp_q[0].cyc, exp_q[0].ev);
            void'(exp_q.pop_front());
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h required=%0h", name, cyc, got, req);
        end
    endtask

    task automatic drive(input int b, input logic v);
        case (b)
            0: btn_set = v;
            1: btn_inc = v;
            default: btn_sw = v;
        endcase
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Press button b for hold sampled cycles, then idle
    task automatic run_vec(input int b, input int hold, input logic [3:0] ev, input int lat);
        int n;
        @(negedge clk);
        n = cyc + 1;
        if (ev != EV_NONE) exp_q.push_back('{n + lat, ev});
        drive(b, 1'b1);
        repeat (hold) @(negedge clk);
        drive(b, 1'b0);
        repeat (40) @(negedge clk);
    endtask

    vec_t vecs[10];

    initial begin
        int n;
        vecs[0] = '{0, 30, EV_SET,  7};
        vecs[1] = '{2,  8, EV_SW,   7};
        vecs[2] = '{1,  3, EV_NONE, 0};
        vecs[3] = '{1, 10, EV_INC, 18};
        vecs[4] = '{1,  4, EV_INC, 12};
        vecs[5] = '{0,  3, EV_NONE, 0};
        vecs[6] = '{1, 19, EV_INC, 27};
        vecs[7] = '{1, 20, EV_LINC, 27};
        vecs[8] = '{2,  4, EV_SW,   7};
        vecs[9] = '{1, 50, EV_LINC, 27};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({o_sw, o_set, o_linc, o_inc, o_inc_held}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i].btn, vecs[i].hold, vecs[i].ev, vecs[i].lat);
        end

        // INC long hold with debounced level timing
        @(negedge clk);
        n = cyc + 1;
        exp_q.push_back('{n + 27, EV_LINC});
        btn_inc = 1'b1;
        wait_cyc(n + 5);
        chk("inc_held_pre", 32'(o_inc_held), 32'd0);
        wait_cyc(n + 6);
        chk("inc_held_rise", 32'(o_inc_held), 32'd1);
        wait_cyc(n + 49);
        @(negedge clk);
        btn_inc = 1'b0;
        wait_cyc(n + 55);
        chk("inc_held_pre_fall", 32'(o_inc_held), 32'd1);
        wait_cyc(n + 56);
        chk("inc_held_fall", 32'(o_inc_held), 32'd0);
        repeat (30) @(negedge clk);

        // SET and SW together: sw first, set next cycle
        @(negedge clk);
        n = cyc + 1;
        exp_q.push_back('{n + 7, EV_SW});
        exp_q.push_back('{n + 8, EV_SET});
        btn_set = 1'b1;
        btn_sw  = 1'b1;
        repeat (10) @(negedge clk);
        btn_set = 1'b0;
        btn_sw  = 1'b0;
        repeat (30) @(negedge clk);

        // SW held through reset: no event until a fresh press
        @(negedge clk);
        rst    = 1'b1;
        btn_sw = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        btn_sw = 1'b0;
        repeat (20) @(negedge clk);
        run_vec(2, 8, EV_SW, 7);

        // Reset while INC classifier is mid-press
        @(negedge clk);
        n = cyc + 1;
        btn_inc = 1'b1;
        wait_cyc(n + 19);
        chk("inc_held_before_rst", 32'(o_inc_held), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        wait_cyc(n + 20);
        chk("mid_reset_outputs", 32'({o_sw, o_set, o_linc, o_inc, o_inc_held}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        btn_inc = 1'b0;
        repeat (30) @(negedge clk);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
